// File: rtl/proto_wire_pkg.sv
// Protobuf wire-format types, widths and helpers shared by encoder and decoder.
`timescale 1ns/1ps
package proto_wire_pkg;
    import user_tree_pkg::IDENTIFIER_SIZE;

    typedef enum logic [2:0] {
        WT_VARINT = 3'd0,
        WT_I64    = 3'd1,
        WT_LEN    = 3'd2,
        WT_I32    = 3'd5
    } wire_type_e;

    localparam int ID_W             = IDENTIFIER_SIZE;
    localparam int TAG_W            = IDENTIFIER_SIZE + 3;
    localparam int VALUE_W          = 64;
    localparam int MAX_VARINT_BYTES = 10;

    // sint32/sint64 mapping: small magnitudes of either sign become small unsigned values.
    function automatic logic [63:0] zigzag64(input logic [63:0] v);
        return (v << 1) ^ {64{v[63]}};
    endfunction

    // Wire types this encoder knows how to serialise (groups 3/4 and 6/7 are rejected).
    function automatic logic wt_supported(input logic [2:0] wt);
        return (wt == WT_VARINT) || (wt == WT_I64) || (wt == WT_LEN) || (wt == WT_I32);
    endfunction

endpackage

// File: rtl/user_tree_pkg.sv
// Shared tree-wide sizing constants used by the protobuf wire blocks.
`timescale 1ns/1ps
package user_tree_pkg;

    // Width of a protobuf field number carried through the tree.
    localparam int IDENTIFIER_SIZE = 8;

endpackage

// File: rtl/proto_field_encoder_if.sv
// Request and byte-stream bundle of the protobuf field encoder.
// Handshake: a request moves when in_valid && in_ready, a byte moves when
// out_valid && out_ready; a valid side holds its payload stable until it moves.
`timescale 1ns/1ps
interface proto_field_encoder_if;
    import proto_wire_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [ID_W-1:0]    in_field_id;
    logic [2:0]         in_wire_type;
    logic [VALUE_W-1:0] in_value;
    logic               in_zigzag;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_byte;
    logic               out_last;
    logic               err_wire_type;
    logic [1:0]         dbg_state;

    modport master (
        output in_valid, in_field_id, in_wire_type, in_value, in_zigzag, out_ready,
        input  in_ready, out_valid, out_byte, out_last, err_wire_type, dbg_state
    );

    modport slave (
        input  in_valid, in_field_id, in_wire_type, in_value, in_zigzag, out_ready,
        output in_ready, out_valid, out_byte, out_last, err_wire_type, dbg_state
    );

endinterface

// File: rtl/proto_varint_emitter.sv
// Varint byte generator: load a value, then step once per emitted byte.
// The current byte is held in a register so the stream output is flop-driven.
`timescale 1ns/1ps
module proto_varint_emitter
    import proto_wire_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [63:0] load_value,
    input  logic        step,
    output logic [7:0]  byte_o,
    output logic        done
);

    logic [7:0]  vbyte_q, vbyte_d;
    logic [63:0] rest_q, rest_d;

    // Next byte: {continuation, low 7 bits}; remainder shifts down 7 per byte.
    always_comb begin
        vbyte_d = vbyte_q;
        rest_d  = rest_q;
        if (load) begin
            vbyte_d = {|load_value[63:7], load_value[6:0]};
            rest_d  = load_value >> 7;
        end else if (step) begin
            vbyte_d = {|rest_q[63:7], rest_q[6:0]};
            rest_d  = rest_q >> 7;
        end
    end

    // Byte and remainder registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vbyte_q <= 8'h00;
            rest_q  <= 64'h0;
        end else begin
            vbyte_q <= vbyte_d;
            rest_q  <= rest_d;
        end
    end

    assign byte_o = vbyte_q;
    // Without a continuation bit the current byte closes the varint.
    assign done   = ~vbyte_q[7];

endmodule

// File: rtl/proto_field_encoder.sv
// Protobuf field serialiser: one {id, wire type, value} request in, tag varint
// plus payload bytes out. Optional zigzag for VARINT under `PROTO_ZIGZAG_EN.
`timescale 1ns/1ps
module proto_field_encoder
    import proto_wire_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    proto_field_encoder_if.slave  bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_TAG     = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  wt_q, wt_d;
    logic [63:0] val_q, val_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        em_load, em_step, em_done;
    logic [63:0] em_value;
    logic [7:0]  em_byte;

    logic        fixed_payload;
    logic        out_valid;
    logic        xfer;
    logic        last_byte;
    logic [TAG_W-1:0] tag;
    logic [63:0] payload_value;

    proto_varint_emitter u_emitter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (em_load),
        .load_value (em_value),
        .step       (em_step),
        .byte_o     (em_byte),
        .done       (em_done)
    );

    assign tag           = {bus.in_field_id, bus.in_wire_type};
    assign fixed_payload = (wt_q == WT_I32) || (wt_q == WT_I64);
    assign out_valid     = (state_q != S_IDLE);
    assign xfer          = out_valid && bus.out_ready;
    assign last_byte     = (state_q == S_PAYLOAD) && (fixed_payload ? (cnt_q == 3'd0) : em_done);

    // Value latched on accept: I32 keeps only its low word, VARINT may be zigzagged.
`ifdef PROTO_ZIGZAG_EN
    always_comb begin
        payload_value = bus.in_value;
        if (bus.in_wire_type == WT_I32) begin
            payload_value = {32'h0, bus.in_value[31:0]};
        end else if ((bus.in_wire_type == WT_VARINT) && bus.in_zigzag) begin
            payload_value = zigzag64(bus.in_value);
        end
    end
`else
    logic unused_zigzag;
    assign unused_zigzag = bus.in_zigzag;

    always_comb begin
        payload_value = bus.in_value;
        if (bus.in_wire_type == WT_I32) begin
            payload_value = {32'h0, bus.in_value[31:0]};
        end
    end
`endif

    // Field FSM: accept in IDLE, stream tag varint, then stream the payload.
    always_comb begin
        state_d  = state_q;
        wt_d     = wt_q;
        val_d    = val_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        em_load  = 1'b0;
        em_step  = 1'b0;
        em_value = 64'h0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (wt_supported(bus.in_wire_type)) begin
                        state_d  = S_TAG;
                        wt_d     = bus.in_wire_type;
                        val_d    = payload_value;
                        cnt_d    = (bus.in_wire_type == WT_I64) ? 3'd7 : 3'd3;
                        em_load  = 1'b1;
                        em_value = 64'(tag);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_TAG: begin
                if (xfer) begin
                    if (em_done) begin
                        state_d = S_PAYLOAD;
                        if (!fixed_payload) begin
                            em_load  = 1'b1;
                            em_value = val_q;
                        end
                    end else begin
                        em_step = 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    if (last_byte) begin
                        state_d = S_IDLE;
                    end else if (fixed_payload) begin
                        val_d = val_q >> 8;
                        cnt_d = cnt_q - 3'd1;
                    end else begin
                        em_step = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, latched request and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wt_q    <= 3'd0;
            val_q   <= 64'h0;
            cnt_q   <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wt_q    <= wt_d;
            val_q   <= val_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Stream outputs are selected from registers only; fixed payloads come LSB first.
    always_comb begin
        bus.out_byte = 8'h00;
        if (state_q == S_TAG) begin
            bus.out_byte = em_byte;
        end else if (state_q == S_PAYLOAD) begin
            bus.out_byte = fixed_payload ? val_q[7:0] : em_byte;
        end
    end

    assign bus.in_ready      = (state_q == S_IDLE);
    assign bus.out_valid     = out_valid;
    assign bus.out_last      = last_byte;
    assign bus.err_wire_type = err_q;
    assign bus.dbg_state     = state_q;

endmodule
